// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - N-to-1 registered mux with round-robin/fixed-priority arbitration and burst lock
module mux_arbiter #(
  parameter int WIDTH = 24,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int CH_W  = $clog2(N)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N*WIDTH-1:0]   Hyrja,
  input  logic [N-1:0]         HyrjaValid,
  input  logic [N-1:0]         HyrjaLock,
  output logic [N-1:0]         HyrjaReady,
  output logic [WIDTH-1:0]     Dalja,
  output logic                 DaljaValid,
  input  logic                 DaljaReady,
  output logic [CH_W-1:0]      Kanali,
  output logic                 Locked
);

  localparam logic [0:0] FREE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]      state;
  logic [CH_W-1:0] lock_ch;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] gnt;
  logic [CH_W-1:0] idx;
  logic [CH_W-1:0] ptr_nxt;
  logic            found;
  logic            le;
  logic            xfer;
  int              j;

  assign le     = !DaljaValid || DaljaReady;
  assign Locked = (state == LOCKED);

  // A locked channel is the only candidate, whether or not it is valid.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    if (state == LOCKED) begin
      gnt   = lock_ch;
      found = HyrjaValid[lock_ch];
    end else if (MODE == 1) begin
      for (int k = 0; k < N; k++) begin
        idx = CH_W'(k);
        if (!found && HyrjaValid[idx]) begin
          found = 1'b1;
          gnt   = idx;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        idx = CH_W'(j);
        if (!found && HyrjaValid[idx]) begin
          found = 1'b1;
          gnt   = idx;
        end
      end
    end
  end

  assign xfer    = !Reset && le && found;
  assign ptr_nxt = (gnt == CH_W'(N - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    HyrjaReady = '0;
    if (xfer) HyrjaReady[gnt] = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Dalja      <= '0;
      DaljaValid <= 1'b0;
      Kanali     <= '0;
      state      <= FREE;
      lock_ch    <= '0;
      ptr        <= '0;
    end else begin
      if (xfer) begin
        Dalja      <= Hyrja[gnt*WIDTH +: WIDTH];
        Kanali     <= gnt;
        DaljaValid <= 1'b1;
        if (MODE == 0) ptr <= ptr_nxt;
        else           ptr <= '0;
        if (HyrjaLock[gnt]) begin
          state   <= LOCKED;
          lock_ch <= gnt;
        end else begin
          state   <= FREE;
        end
      end else if (le) begin
        DaljaValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - scoreboard bench for mux_arbiter in both arbitration modes
module tb_mux_arbiter;

  localparam int W = 24;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] d;
    logic         lk;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  logic [N*W-1:0] h0, h1;
  logic [N-1:0]   v0, v1, l0, l1, rdy0, rdy1;
  logic [W-1:0]   d0, d1;
  logic           dv0, dv1, dr0, dr1, lk0, lk1;
  logic [1:0]     k0, k1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;

  mux_arbiter #(.WIDTH(W), .N(N), .MODE(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Hyrja(h0), .HyrjaValid(v0), .HyrjaLock(l0),
    .HyrjaReady(rdy0), .Dalja(d0), .DaljaValid(dv0), .DaljaReady(dr0),
    .Kanali(k0), .Locked(lk0)
  );

  mux_arbiter #(.WIDTH(W), .N(N), .MODE(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Hyrja(h1), .HyrjaValid(v1), .HyrjaLock(l1),
    .HyrjaReady(rdy1), .Dalja(d1), .DaljaValid(dv1), .DaljaReady(dr1),
    .Kanali(k1), .Locked(lk1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push0(input logic [1:0] ch, input logic [W-1:0] d, input logic lk);
    exp_t e;
    e.ch = ch; e.d = d; e.lk = lk;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [1:0] ch, input logic [W-1:0] d, input logic lk);
    exp_t e;
    e.ch = ch; e.d = d; e.lk = lk;
    q1.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (!Reset && dv0 && dr0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon0_unexpected: got ch %0d data %0h expected none", k0, d0);
      end else begin
        e = q0.pop_front();
        chk("mon0_kanali", 32'(k0), 32'(e.ch));
        chk("mon0_dalja", 32'(d0), 32'(e.d));
        chk("mon0_locked", 32'(lk0), 32'(e.lk));
      end
    end
  end

  always @(negedge Clock) begin
    exp_t e;
    if (!Reset && dv1 && dr1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon1_unexpected: got ch %0d data %0h expected none", k1, d1);
      end else begin
        e = q1.pop_front();
        chk("mon1_kanali", 32'(k1), 32'(e.ch));
        chk("mon1_dalja", 32'(d1), 32'(e.d));
        chk("mon1_locked", 32'(lk1), 32'(e.lk));
      end
    end
  end

  initial begin
    logic [N-1:0] oh;
    h0 = '0; h1 = '0; v0 = '0; v1 = '0; l0 = '0; l1 = '0; dr0 = 1'b0; dr1 = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    v0 = 4'hF; dr0 = 1'b1;
    #1;
    chk("rst_valid", 32'(dv0), 0);
    chk("rst_locked", 32'(lk0), 0);
    chk("rst_dalja", 32'(d0), 0);
    chk("rst_kanali", 32'(k0), 0);
    chk("rst_ready", 32'(rdy0), 0);
    tick();
    Reset = 1'b0;

    // round-robin rotation across all four channels
    h0 = {24'h00000D, 24'h00000C, 24'h00000B, 24'h00000A};
    v0 = 4'hF; l0 = '0; dr0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push0(2'(i % 4), 24'h00000A + 24'(i % 4), 1'b0);
      oh = 4'(1 << (i % 4));
      #1 chk("rr_ready", 32'(rdy0), 32'(oh));
      tick();
    end
    v0 = '0;
    tick();

    // backpressure holds the output word and blocks all grants
    h0 = {24'h00000D, 24'h00000C, 24'h123456, 24'h00000A};
    v0 = 4'b0010;
    push0(2'd1, 24'h123456, 1'b0);
    tick();
    dr0 = 1'b0;
    h0 = {24'h00000D, 24'h00000C, 24'h00000B, 24'h00000A};
    v0 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 32'(rdy0), 0);
      chk("bp_dalja", 32'(d0), 32'h123456);
      chk("bp_valid", 32'(dv0), 1);
      tick();
    end
    dr0 = 1'b1;
    push0(2'd2, 24'h00000C, 1'b0);
    tick();
    v0 = '0;
    tick();
    tick();

    // lock burst on channel 2 with competitors 0 and 3 valid
    v0 = 4'b0010;
    push0(2'd1, 24'h00000B, 1'b0);
    tick();
    v0 = 4'b1101;
    for (int b = 1; b <= 3; b++) begin
      h0[2*W +: W] = 24'h200000 + 24'(b);
      l0 = (b < 3) ? 4'b0100 : 4'b0000;
      push0(2'd2, 24'h200000 + 24'(b), (b < 3));
      #1 chk("lock_ready", 32'(rdy0), 32'b0100);
      tick();
    end
    l0 = '0;
    push0(2'd3, 24'h00000D, 1'b0);
    #1 chk("after_lock_ready", 32'(rdy0), 32'b1000);
    tick();
    v0 = '0;
    tick();
    tick();

    // locked channel goes idle: nobody else is served
    v0 = 4'b0010; l0 = 4'b0010;
    h0[1*W +: W] = 24'h100001;
    push0(2'd1, 24'h100001, 1'b1);
    tick();
    v0 = 4'b0001; l0 = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("gap_ready", 32'(rdy0), 0);
      chk("gap_locked", 32'(lk0), 1);
      tick();
    end
    v0 = 4'b0011;
    h0[1*W +: W] = 24'h100002;
    push0(2'd1, 24'h100002, 1'b0);
    #1 chk("gap_release_ready", 32'(rdy0), 32'b0010);
    tick();
    v0 = 4'b0001;
    push0(2'd0, 24'h00000A, 1'b0);
    #1 chk("gap_ch0_ready", 32'(rdy0), 32'b0001);
    tick();
    v0 = '0;
    tick();
    tick();

    // fixed priority instance
    h1 = {24'h00000D, 24'h00000C, 24'h00000B, 24'h00000A};
    v1 = 4'b1010; dr1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push1(2'd1, 24'h00000B, 1'b0);
      #1 chk("fp_ready_ch1", 32'(rdy1), 32'b0010);
      tick();
    end
    v1 = 4'b1000;
    push1(2'd3, 24'h00000D, 1'b0);
    #1 chk("fp_ready_ch3", 32'(rdy1), 32'b1000);
    tick();
    v1 = 4'b1011;
    push1(2'd0, 24'h00000A, 1'b0);
    #1 chk("fp_ready_ch0", 32'(rdy1), 32'b0001);
    tick();
    v1 = '0;
    tick();
    tick();

    // asynchronous reset in the middle of a locked burst
    v0 = 4'b0100; l0 = 4'b0100;
    h0[2*W +: W] = 24'h2A2A2A;
    push0(2'd2, 24'h2A2A2A, 1'b1);
    tick();
    dr0 = 1'b0;
    #2;
    Reset = 1'b1;
    q0.delete();
    #1;
    chk("arst_valid", 32'(dv0), 0);
    chk("arst_locked", 32'(lk0), 0);
    chk("arst_dalja", 32'(d0), 0);
    chk("arst_ready", 32'(rdy0), 0);
    tick();
    Reset = 1'b0;
    h0 = {24'h00000D, 24'h00000C, 24'h00000B, 24'h00000A};
    v0 = 4'hF; l0 = '0; dr0 = 1'b1;
    push0(2'd0, 24'h00000A, 1'b0);
    #1 chk("post_rst_ready", 32'(rdy0), 32'b0001);
    tick();
    v0 = '0;
    tick();
    tick();

    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
